// File: rtl/aes_shift_mix_stage_if.sv
// ---------------------------------------------------------------------------
// aes_shift_mix_stage_if
//   Handshake bundle for the forward ShiftRows/MixColumns/AddRoundKey stage.
//
//   Input channel  : in_valid, in_ready, in_state, round_key, last_round
//   Output channel : out_valid, out_ready, out_state
//
//   All 128-bit vectors are declared [0:127]. Byte k occupies bits
//   [8k:8k+7], so byte 0 is the leftmost byte of the usual hex string.
//   Byte index = 4*col + row.
//
//   modport master : the side that produces states and consumes results
//   modport slave  : the pipeline stage itself
// ---------------------------------------------------------------------------
interface aes_shift_mix_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic [0:127] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;

  modport master (
    output in_valid,
    output in_state,
    output round_key,
    output last_round,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state
  );

  modport slave (
    input  in_valid,
    input  in_state,
    input  round_key,
    input  last_round,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state
  );
endinterface

// File: rtl/aes_shift_mix_stage.sv
// ---------------------------------------------------------------------------
// aes_shift_mix_stage
//   Forward AES round back-end: ShiftRows, then MixColumns (skipped on the
//   final round), then AddRoundKey. Sits between the S-box stage and the
//   round-state register of the iterative AES-128 encryptor.
//
//   Two registered stages:
//     S1 : ShiftRows(in_state), round key, last_round flag
//     S2 : MixColumns(S1) ^ key  (or S1 ^ key on the last round) = out_state
//
//   Ports
//     clk    : clock, all state changes on the rising edge
//     reset  : synchronous, active-high; clears both stages and out_state
//     bus    : aes_shift_mix_stage_if.slave (valid/ready in and out)
//
//   Parameter
//     ENABLE_KEY_ADD : 1 = XOR the round key into the result,
//                      0 = key ignored (shift/mix debug)
//
//   Flow control is a plain two-entry pipeline without a skid buffer:
//   in_ready is combinational from out_ready when both stages are full.
// ---------------------------------------------------------------------------
module aes_shift_mix_stage #(
  parameter bit ENABLE_KEY_ADD = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  aes_shift_mix_stage_if.slave        bus
);

  // -------------------------------------------------------------------------
  // GF(2^8) helpers
  // -------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    mul3 = xtime(x) ^ x;
  endfunction

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  logic         s1_valid_q;
  logic [0:127] s1_sr_q;
  logic [0:127] s1_key_q;
  logic         s1_last_q;

  logic         s2_valid_q;
  logic [0:127] s2_state_q;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic in_fire;
  logic out_fire;
  logic s2_advance;
  logic in_ready_int;

  // S2 can take S1's contents when it is empty or being drained this cycle.
  assign s2_advance   = s1_valid_q & (~s2_valid_q | bus.out_ready);
  // S1 is free when empty, or when its current occupant moves into S2.
  assign in_ready_int = ~s1_valid_q | s2_advance;
  assign in_fire      = bus.in_valid & in_ready_int;
  assign out_fire     = s2_valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_state = s2_state_q;

  // -------------------------------------------------------------------------
  // Stage 1 datapath: ShiftRows is pure wiring.
  // Output byte (r + 4c) comes from input byte (r + 4*((c + r) mod 4)),
  // i.e. row r rotates left by r positions.
  // -------------------------------------------------------------------------
  logic [0:127] sr_d;
  logic [0:127] key_d;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : gen_shift_rows
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
      assign sr_d[8*gi +: 8] = bus.in_state[8*SRC +: 8];
    end
  endgenerate

  // With key addition disabled the key register simply holds zero, so the
  // stage-2 XOR degenerates to a pass-through.
  assign key_d = ENABLE_KEY_ADD ? bus.round_key : 128'h0;

  // -------------------------------------------------------------------------
  // Stage 2 datapath: MixColumns on each 32-bit column, optional bypass on
  // the final round, then AddRoundKey.
  // -------------------------------------------------------------------------
  logic [0:127] mc_d;
  logic [0:127] s2_d;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_mix_columns
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;

      assign a0 = s1_sr_q[32*gi      +: 8];
      assign a1 = s1_sr_q[32*gi + 8  +: 8];
      assign a2 = s1_sr_q[32*gi + 16 +: 8];
      assign a3 = s1_sr_q[32*gi + 24 +: 8];

      assign b0 = xtime(a0) ^ mul3(a1)  ^ a2        ^ a3;
      assign b1 = a0        ^ xtime(a1) ^ mul3(a2)  ^ a3;
      assign b2 = a0        ^ a1        ^ xtime(a2) ^ mul3(a3);
      assign b3 = mul3(a0)  ^ a1        ^ a2        ^ xtime(a3);

      assign mc_d[32*gi      +: 8] = s1_last_q ? a0 : b0;
      assign mc_d[32*gi + 8  +: 8] = s1_last_q ? a1 : b1;
      assign mc_d[32*gi + 16 +: 8] = s1_last_q ? a2 : b2;
      assign mc_d[32*gi + 24 +: 8] = s1_last_q ? a3 : b3;
    end
  endgenerate

  assign s2_d = mc_d ^ s1_key_q;

  // -------------------------------------------------------------------------
  // Stage 1 register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sr_q    <= '0;
      s1_key_q   <= '0;
      s1_last_q  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_sr_q    <= sr_d;
        s1_key_q   <= key_d;
        s1_last_q  <= bus.last_round;
      end else if (s2_advance) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 register. out_state keeps its last value after being consumed;
  // only the valid flag drops.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_state_q <= '0;
    end else begin
      if (s2_advance) begin
        s2_valid_q <= 1'b1;
        s2_state_q <= s2_d;
      end else if (out_fire) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_shift_mix_stage.sv
// ---------------------------------------------------------------------------
// tb_aes_shift_mix_stage
//   Directed known-answer vectors plus randomized streaming against a
//   byte-level reference model of the AES round back-end. Two instances:
//   dut_main (key addition on) and dut_nk (key addition off).
// ---------------------------------------------------------------------------
module tb_aes_shift_mix_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_shift_mix_stage_if if_main ();
  aes_shift_mix_stage_if if_nk ();

  aes_shift_mix_stage #(.ENABLE_KEY_ADD(1'b1)) dut_main (
    .clk   (clk),
    .reset (rst),
    .bus   (if_main)
  );

  aes_shift_mix_stage #(.ENABLE_KEY_ADD(1'b0)) dut_nk (
    .clk   (clk),
    .reset (rst),
    .bus   (if_nk)
  );

  int errors = 0;
  int checks = 0;

  // Expected results in order of acceptance, and count of items in flight.
  logic [0:127] exp_q[$];
  int           in_flight;
  bit           hold_prev;
  logic [0:127] prev_state;
  int           outs_seen;

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: byte arrays, generic GF(2^8) multiply by polynomial
  // reduction modulo x^8+x^4+x^3+x+1.
  // ---------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input int n);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (n[i]) prod = prod ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (prod[k]) prod = prod ^ (15'h11b << (k - 8));
    return prod[7:0];
  endfunction

  function automatic logic [0:127] ref_round(input logic [0:127] st,
      input logic [0:127] key, input bit last, input bit use_key);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [0:127] res;
    int           m  [4][4];
    m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    for (int k = 0; k < 16; k++) b[k] = st[8*k +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r + 4*c] = b[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (last) mc[r + 4*c] = sr[r + 4*c];
        else begin
          mc[r + 4*c] = 8'h00;
          for (int j = 0; j < 4; j++)
            mc[r + 4*c] = mc[r + 4*c] ^ gmul(sr[j + 4*c], m[r][j]);
        end
      end
    for (int k = 0; k < 16; k++)
      res[8*k +: 8] = mc[k] ^ (use_key ? key[8*k +: 8] : 8'h00);
    return res;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock of the main DUT with scoreboard checks. Inputs must already be
  // driven (we are at posedge+1). Ends at the next posedge+1.
  task automatic run_cycle(input string tag);
    bit in_fire;
    bit out_fire;
    #2;
    in_fire  = if_main.in_valid  && if_main.in_ready;
    out_fire = if_main.out_valid && if_main.out_ready;
    // With two entries the stage is full; only a drain frees a slot.
    check({tag, "_in_ready"}, {127'b0, if_main.in_ready},
          {127'b0, (in_flight < 2) || if_main.out_ready});
    if (hold_prev) begin
      check({tag, "_stall_valid"}, {127'b0, if_main.out_valid}, 128'h1);
      check({tag, "_stall_state"}, if_main.out_state, prev_state);
    end
    if (out_fire) begin
      if (exp_q.size() == 0)
        check({tag, "_spurious_out"}, {127'b0, out_fire}, 128'h0);
      else
        check({tag, "_out_state"}, if_main.out_state, exp_q.pop_front());
      outs_seen++;
      in_flight--;
    end
    if (in_fire) begin
      exp_q.push_back(ref_round(if_main.in_state, if_main.round_key,
                                if_main.last_round, 1'b1));
      in_flight++;
    end
    hold_prev  = if_main.out_valid && !if_main.out_ready;
    prev_state = if_main.out_state;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    in_flight = 0;
    hold_prev = 1'b0;
    outs_seen = 0;
  endtask

  // Known-answer vector on the main DUT with exact latency check.
  task automatic kat_main(input string tag, input logic [0:127] st,
      input logic [0:127] key, input bit last, input logic [0:127] expv);
    if_main.in_valid   = 1'b1;
    if_main.in_state   = st;
    if_main.round_key  = key;
    if_main.last_round = last;
    if_main.out_ready  = 1'b1;
    #2;
    check({tag, "_accept"}, {127'b0, if_main.in_ready}, 128'h1);
    @(posedge clk);
    #1;
    if_main.in_valid   = 1'b0;
    if_main.round_key  = rand128();
    if_main.last_round = ~last;
    check({tag, "_valid_n1"}, {127'b0, if_main.out_valid}, 128'h0);
    @(posedge clk);
    #1;
    check({tag, "_valid_n2"}, {127'b0, if_main.out_valid}, 128'h1);
    check({tag, "_state"}, if_main.out_state, expv);
    @(posedge clk);
    #1;
    check({tag, "_drained"}, {127'b0, if_main.out_valid}, 128'h0);
  endtask

  logic [0:127] st_arr  [8];
  logic [0:127] key_arr [8];
  bit           last_arr[8];
  logic [0:127] nk_key;

  initial begin
    model_clear();
    rst = 1'b1;
    if_main.in_valid = 1'b0; if_main.in_state = '0; if_main.round_key = '0;
    if_main.last_round = 1'b0; if_main.out_ready = 1'b0;
    if_nk.in_valid = 1'b0; if_nk.in_state = '0; if_nk.round_key = '0;
    if_nk.last_round = 1'b0; if_nk.out_ready = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {127'b0, if_main.out_valid}, 128'h0);
    check("rst_out_state", if_main.out_state, 128'h0);
    check("rst_in_ready", {127'b0, if_main.in_ready}, 128'h1);

    // ---- known-answer vectors ----
    kat_main("fips_r1", 128'hd42711aee0bf98f1b8b45de51e415230,
             128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
             128'ha49c7ff2689f352b6b5bea43026a5049);
    kat_main("fips_r10", 128'he9098972cb31075f3d327d94af2e2cb5,
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1,
             128'h3925841d02dc09fbdc118597196a0b32);

    // ---- key addition disabled: pure ShiftRows, key ignored ----
    nk_key = rand128();
    if_nk.in_valid   = 1'b1;
    if_nk.in_state   = 128'hd42711aee0bf98f1b8b45de51e415230;
    if_nk.round_key  = nk_key;
    if_nk.last_round = 1'b1;
    if_nk.out_ready  = 1'b1;
    @(posedge clk);
    #1;
    if_nk.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("nokey_valid", {127'b0, if_nk.out_valid}, 128'h1);
    check("nokey_state", if_nk.out_state, 128'hd4bf5d30e0b452aeb84111f11e2798e5);

    // ---- streaming 8 states with a 4-cycle stall ----
    model_clear();
    for (int i = 0; i < 8; i++) begin
      st_arr[i]   = rand128();
      key_arr[i]  = rand128();
      last_arr[i] = ($urandom_range(0, 3) == 0);
    end
    begin
      int idx;
      int cyc;
      idx = 0;
      cyc = 0;
      while ((idx < 8 || outs_seen < 8) && cyc < 200) begin
        if_main.in_valid  = (idx < 8);
        if (idx < 8) begin
          if_main.in_state   = st_arr[idx];
          if_main.round_key  = key_arr[idx];
          if_main.last_round = last_arr[idx];
        end
        if_main.out_ready = !(cyc >= 3 && cyc < 7);
        #2;
        if (if_main.in_valid && if_main.in_ready) idx++;
        #(-0);
        run_cycle_adjusted();
        cyc++;
      end
      if_main.in_valid = 1'b0;
      check("stream_count", 128'(outs_seen), 128'd8);
    end

    // ---- simultaneous accept/emit for 16 cycles ----
    model_clear();
    for (int k = 0; k < 16; k++) begin
      if_main.in_valid   = 1'b1;
      if_main.in_state   = rand128();
      if_main.round_key  = rand128();
      if_main.last_round = $urandom_range(0, 1);
      if_main.out_ready  = 1'b1;
      if (k >= 2)
        check("full_rate_valid", {127'b0, if_main.out_valid}, 128'h1);
      run_cycle("full_rate");
    end
    check("full_rate_outs", 128'(outs_seen), 128'd14);
    if_main.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) run_cycle("full_rate_drain");
    check("full_rate_total", 128'(outs_seen), 128'd16);

    // ---- reset with both stages valid ----
    model_clear();
    if_main.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_main.in_valid   = 1'b1;
      if_main.in_state   = rand128();
      if_main.round_key  = rand128();
      if_main.last_round = 1'b0;
      run_cycle("fill");
    end
    check("fill_out_valid", {127'b0, if_main.out_valid}, 128'h1);
    rst = 1'b1;
    if_main.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_main.in_valid = 1'b0;
    check("midrst_out_valid", {127'b0, if_main.out_valid}, 128'h0);
    check("midrst_out_state", if_main.out_state, 128'h0);
    check("midrst_in_ready", {127'b0, if_main.in_ready}, 128'h1);
    model_clear();
    for (int k = 0; k < 4; k++) begin
      check("post_rst_no_out", {127'b0, if_main.out_valid}, 128'h0);
      run_cycle("post_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Stream loop helper: the index bookkeeping above already consumed 2 time
  // units of the cycle, so the scoreboard step here starts at posedge+3.
  task automatic run_cycle_adjusted();
    bit in_fire;
    bit out_fire;
    in_fire  = if_main.in_valid  && if_main.in_ready;
    out_fire = if_main.out_valid && if_main.out_ready;
    check("stream_in_ready", {127'b0, if_main.in_ready},
          {127'b0, (in_flight < 2) || if_main.out_ready});
    if (hold_prev) begin
      check("stream_stall_valid", {127'b0, if_main.out_valid}, 128'h1);
      check("stream_stall_state", if_main.out_state, prev_state);
    end
    if (out_fire) begin
      if (exp_q.size() == 0)
        check("stream_spurious_out", {127'b0, out_fire}, 128'h0);
      else
        check("stream_out_state", if_main.out_state, exp_q.pop_front());
      outs_seen++;
      in_flight--;
    end
    if (in_fire) begin
      exp_q.push_back(ref_round(if_main.in_state, if_main.round_key,
                                if_main.last_round, 1'b1));
      in_flight++;
    end
    hold_prev  = if_main.out_valid && !if_main.out_ready;
    prev_state = if_main.out_state;
    @(posedge clk);
    #1;
  endtask

endmodule
